cp0_irq_ctrl: RTL and testbench
===============================

Name: cp0_irq_ctrl

Overview:
- Parametrised CP0 successor for the pipelined MIPS core.
- Accepts NUM_IRQ external interrupt lines, each with a synchronizer, rising-edge detection and a sticky pending bit.
- Provides per-line masking, a global enable, an exception-level lock (no re-entry), fixed priority and optional vectored dispatch.
- MFC0 reads in ID, MTC0/ERET act in EXE; jump_en/jump_addr drive the PC-redirect and flush logic.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- SYNC_STAGES, 2, synchronizer flops per line (>=2).
- VEC_SHIFT, 4, log2 of vector spacing in bytes when vectored mode is on.

Ports:
- clk  in  1  main clock, posedge.
- rst  in  1  synchronous reset, active-high.
- oper  in  2  CP0 op: EXE_CP_NONE / EXE_CP_MFC0 / EXE_CP_MTC0 / EXE_CP0_ERET.
- addr_r  in  5  MFC0 register address.
- data_r  out  32  MFC0 read data.
- addr_w  in  5  MTC0 register address.
- data_w  in  32  MTC0 write data.
- ir_en  in  1  pipeline can accept an interrupt this cycle (ret_addr valid, no stall).
- ir_in  in  NUM_IRQ  asynchronous interrupt lines, level, rising edge significant.
- ret_addr  in  32  address saved to EPC when an interrupt is taken.
- jump_en  out  1  redirect PC this cycle (interrupt taken or ERET).
- jump_addr  out  32  redirect target.
- irq_taken  out  1  pulse: interrupt accepted this cycle; used for flush.

Behaviour:
Register map:
- 0 STATUS: bit0 IE, bit1 EXL, bit2 VEC, bits[8+NUM_IRQ-1:8] IM. Other bits read 0.
- 1 CAUSE: bits[8+NUM_IRQ-1:8] IP (pending), bits[6:2] code = index of the last taken line. IP is write-one-to-clear; code is read-only.
- 2 EPC: read/write.
- 3 EHBR: handler base, read/write, bits[1:0] forced 0.
- Other addresses read 0; writes to them are ignored.

Reset:
- All registers, synchronizer flops and edge history are 0.
- jump_en, irq_taken = 0 during the reset cycle regardless of other inputs.

Input path:
- Each line passes through SYNC_STAGES flops, then an edge detector (synced & ~prev).
- A detected edge sets IP[i] on the next posedge.
- An edge on a line already pending is absorbed; there is no counting.
- Latency: an ir_in rise held from cycle 0 sets IP at posedge SYNC_STAGES+1.

Take condition (combinational from registered state):
- take = ~rst & ir_en & IE & ~EXL & |(IP & IM).
- Selected line id = lowest set index of IP & IM.
- In the take cycle: jump_en=1, irq_taken=1.
- jump_addr = VEC ? EHBR + (id << VEC_SHIFT) : EHBR.
- At posedge: EPC<=ret_addr, EXL<=1, code<=id, IP[id]<=0 (auto-clear on take).

ERET:
- When oper==ERET and not take: jump_en=1, jump_addr=EPC.
- At posedge: EXL<=0.
- ERET with EXL=0 still jumps to EPC.

MFC0:
- data_r = selected register when oper==MFC0, else 0.
- No same-cycle bypass from MTC0; the read returns the pre-edge value.

MTC0:
- Takes effect at posedge when not take.
- Priority rules:
  - take vs MTC0 or ERET in the same cycle: take wins; the MTC0/ERET is dropped because the pipeline flushes that instruction.
  - Edge set vs W1C clear of the same IP bit in the same cycle: set wins.
- A write to STATUS that sets IE while IP&IM is nonzero gives take no earlier than the following cycle.

Defaults:
- jump_addr = 0 when jump_en=0.
- Single-cycle decisions; no FSM beyond EXL; jump_en is never asserted two consecutive cycles for the same event.

Decomposition:
- mips_define.vh holds:
  - oper encodings (EXE_CP_NONE=0, EXE_CP_MFC0=1, EXE_CP_MTC0=2, EXE_CP0_ERET=3).
  - CP0 register addresses (CP0_STATUS=0, CP0_CAUSE=1, CP0_EPC=2, CP0_EHBR=3).
  - STATUS/CAUSE bit positions.
- Sub-module irq_sync_edge (parameter SYNC_STAGES): one line's synchronizer and rising-edge pulse, instantiated NUM_IRQ times by generate.
- Priority encoder and register file stay in cp0_irq_ctrl.

Test Plan:
1. Reset, then MTC0 EHBR=0x100 and STATUS=0x0301 (IE, IM0-1); raise ir_in[1] with ir_en=1, ret_addr=0x40.
   - Expected: after SYNC_STAGES+1 cycles, one cycle with jump_en=1, jump_addr=0x100.
   - Then MFC0 EPC=0x40, CAUSE code=1, STATUS.EXL=1.
2. Raise ir_in[0] and ir_in[2] together with IM=0x7, IE=1, VEC=1, EHBR=0x200.
   - Expected: line 0 taken first, jump_addr=0x200.
   - After ERET (EXL=0): line 2 taken, jump_addr=0x220, EPC holds the new ret_addr.
3. With EXL=1, raise ir_in[0].
   - Expected: IP0=1, no jump_en.
   - ERET gives jump_addr=EPC; the next cycle with ir_en=1 takes the interrupt.
4. Pending IP1 with IM1=0: no take. MTC0 CAUSE bit9=1 clears IP1 (MFC0 CAUSE=0). Clear in the same cycle as a new edge on line 1: IP1 stays 1.
5. Take condition met in the same cycle as MTC0 EPC=0xDEAD.
   - Expected: EPC=ret_addr, the MTC0 is dropped.
   - ir_en=0 blocks the take until ir_en returns to 1.
6. Assert rst while a take condition is pending.
   - Expected: jump_en=0 that cycle; all registers read 0 afterwards.

Source files
------------

// File: rtl/cp0_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl_pkg
// Shared definitions for the CP0 interrupt controller: CP0 operation
// encodings, CP0 register addresses, STATUS/CAUSE bit positions and a
// lowest-set-bit helper used for fixed-priority line selection.
// No ports (package).
// ---------------------------------------------------------------------------
package cp0_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        EXE_CP_NONE  = 2'd0,
        EXE_CP_MFC0  = 2'd1,
        EXE_CP_MTC0  = 2'd2,
        EXE_CP0_ERET = 2'd3
    } cp0_oper_e;

    localparam logic [4:0] CP0_STATUS = 5'd0;
    localparam logic [4:0] CP0_CAUSE  = 5'd1;
    localparam logic [4:0] CP0_EPC    = 5'd2;
    localparam logic [4:0] CP0_EHBR   = 5'd3;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_VEC     = 2;
    localparam int STATUS_IM_LSB  = 8;
    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_IP_LSB   = 8;

    // Index of the lowest set bit; line 0 has the highest priority.
    // Returns 0 for an all-zero vector (callers gate on a nonzero vector).
    function automatic logic [4:0] lowest_set(input logic [7:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// One external interrupt line: SYNC_STAGES-deep synchronizer followed by a
// rising-edge detector.
// Ports:
//   clk     in  main clock, posedge
//   rst     in  synchronous active-high reset
//   irq_i   in  asynchronous interrupt level
//   edge_o  out single-cycle pulse on a synchronized rising edge
// ---------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl
// CP0 interrupt controller for the pipelined MIPS core. Synchronizes
// NUM_IRQ external lines, latches rising edges into sticky pending bits,
// and takes the lowest-numbered pending+unmasked line when globally enabled
// and not already in an exception (EXL). Optional vectored dispatch spaces
// handlers by 2**VEC_SHIFT bytes from EHBR. MFC0 reads are combinational;
// MTC0/ERET commit at the clock edge unless an interrupt is taken in the
// same cycle, in which case the flushed instruction has no effect.
// Ports:
//   clk, rst            clock (posedge), synchronous active-high reset
//   oper                CP0 operation (NONE/MFC0/MTC0/ERET)
//   addr_r, data_r      MFC0 register address and read data
//   addr_w, data_w      MTC0 register address and write data
//   ir_en               pipeline can accept an interrupt this cycle
//   ir_in               asynchronous interrupt lines
//   ret_addr            address saved to EPC on a take
//   jump_en, jump_addr  PC redirect request and target
//   irq_taken           interrupt accepted this cycle (flush)
// ---------------------------------------------------------------------------
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int VEC_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [31:0]        data_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [31:0]        ret_addr,
    output logic               jump_en,
    output logic [31:0]        jump_addr,
    output logic               irq_taken
);

    logic               ie_q,   ie_d;
    logic               exl_q,  exl_d;
    logic               vec_q,  vec_d;
    logic [NUM_IRQ-1:0] im_q,   im_d;
    logic [NUM_IRQ-1:0] ip_q,   ip_d;
    logic [4:0]         code_q, code_d;
    logic [31:0]        epc_q,  epc_d;
    logic [31:2]        ehbr_q, ehbr_d;

    logic [NUM_IRQ-1:0] edge_w;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] take_mask;
    logic [4:0]         take_id;
    logic               take;
    logic [31:0]        ehbr_full;
    logic [31:0]        status_rd;
    logic [31:0]        cause_rd;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .rst   (rst),
            .irq_i (ir_in[g]),
            .edge_o(edge_w[g])
        );
    end

    assign pend      = ip_q & im_q;
    assign take      = ~rst & ir_en & ie_q & ~exl_q & (|pend);
    assign take_id   = lowest_set(8'(pend));
    assign take_mask = take ? (NUM_IRQ'(1) << take_id) : '0;
    assign ehbr_full = {ehbr_q, 2'b00};

    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        vec_d  = vec_q;
        im_d   = im_q;
        code_d = code_q;
        epc_d  = epc_q;
        ehbr_d = ehbr_q;
        ip_d   = ip_q & ~take_mask;

        if (take) begin
            epc_d  = ret_addr;
            exl_d  = 1'b1;
            code_d = take_id;
        end else if (oper == EXE_CP_MTC0) begin
            case (addr_w)
                CP0_STATUS: begin
                    ie_d  = data_w[STATUS_IE];
                    exl_d = data_w[STATUS_EXL];
                    vec_d = data_w[STATUS_VEC];
                    im_d  = data_w[STATUS_IM_LSB +: NUM_IRQ];
                end
                CP0_CAUSE: ip_d  = ip_d & ~data_w[CAUSE_IP_LSB +: NUM_IRQ];
                CP0_EPC:   epc_d = data_w;
                CP0_EHBR:  ehbr_d = data_w[31:2];
                default:   ;
            endcase
        end else if (oper == EXE_CP0_ERET) begin
            exl_d = 1'b0;
        end

        // Applied last so a new edge beats a same-cycle clear of that bit.
        ip_d = ip_d | edge_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            vec_q  <= 1'b0;
            im_q   <= '0;
            ip_q   <= '0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
            ehbr_q <= 30'd0;
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            vec_q  <= vec_d;
            im_q   <= im_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            ehbr_q <= ehbr_d;
        end
    end

    always_comb begin
        jump_en   = 1'b0;
        jump_addr = 32'd0;
        irq_taken = 1'b0;
        if (take) begin
            jump_en   = 1'b1;
            irq_taken = 1'b1;
            jump_addr = vec_q ? ehbr_full + (32'(take_id) << VEC_SHIFT) : ehbr_full;
        end else if (~rst && oper == EXE_CP0_ERET) begin
            jump_en   = 1'b1;
            jump_addr = epc_q;
        end
    end

    always_comb begin
        status_rd = 32'd0;
        status_rd[STATUS_IE]  = ie_q;
        status_rd[STATUS_EXL] = exl_q;
        status_rd[STATUS_VEC] = vec_q;
        status_rd[STATUS_IM_LSB +: NUM_IRQ] = im_q;

        cause_rd = 32'd0;
        cause_rd[CAUSE_CODE_LSB +: 5]     = code_q;
        cause_rd[CAUSE_IP_LSB +: NUM_IRQ] = ip_q;

        data_r = 32'd0;
        if (oper == EXE_CP_MFC0) begin
            case (addr_r)
                CP0_STATUS: data_r = status_rd;
                CP0_CAUSE:  data_r = cause_rd;
                CP0_EPC:    data_r = epc_q;
                CP0_EHBR:   data_r = ehbr_full;
                default:    data_r = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
module tb_cp0_irq_ctrl;

    localparam int NI = 4;
    localparam int SS = 2;
    localparam int VS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    oper = 2'd0;
    logic [4:0]    addr_r = 5'd0;
    logic [31:0]   data_r;
    logic [4:0]    addr_w = 5'd0;
    logic [31:0]   data_w = 32'd0;
    logic          ir_en = 1'b0;
    logic [NI-1:0] ir_in = '0;
    logic [31:0]   ret_addr = 32'd0;
    logic          jump_en;
    logic [31:0]   jump_addr;
    logic          irq_taken;

    cp0_irq_ctrl #(.NUM_IRQ(NI), .SYNC_STAGES(SS), .VEC_SHIFT(VS)) dut (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr),
        .irq_taken(irq_taken)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state (architectural view of CP0)
    int unsigned m_ie, m_exl, m_vec, m_im, m_ip, m_code;
    logic [31:0] m_epc, m_ehbr;
    int unsigned hist [SS+1];   // hist[k] = ir_in sampled k+1 rising edges ago

    // Values captured at the last compare point
    logic        cap_je, cap_it;
    logic [31:0] cap_ja, cap_dr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input int unsigned v);
        for (int i = 0; i < NI; i++) if (((v >> i) & 1) != 0) return i;
        return 0;
    endfunction

    function automatic bit model_take();
        return !rst && ir_en && m_ie != 0 && m_exl == 0 && (m_ip & m_im) != 0;
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_vec = 0; m_im = 0; m_ip = 0; m_code = 0;
        m_epc = 0; m_ehbr = 0;
        for (int k = 0; k <= SS; k++) hist[k] = 0;
    endtask

    task automatic model_out(output logic je, output logic [31:0] ja,
                             output logic it, output logic [31:0] dr);
        int id;
        je = 0; ja = 0; it = 0; dr = 0;
        if (model_take()) begin
            id = lowest(m_ip & m_im);
            je = 1; it = 1;
            ja = (m_vec != 0) ? m_ehbr + 32'(id * (1 << VS)) : m_ehbr;
        end else if (!rst && oper == 2'd3) begin
            je = 1; ja = m_epc;
        end
        if (oper == 2'd1) begin
            case (addr_r)
                5'd0: dr = 32'(m_ie + 2 * m_exl + 4 * m_vec + 256 * m_im);
                5'd1: dr = 32'(256 * m_ip + 4 * m_code);
                5'd2: dr = m_epc;
                5'd3: dr = m_ehbr;
                default: dr = 0;
            endcase
        end
    endtask

    task automatic model_edge();
        int unsigned edges, mask;
        int id;
        mask = (1 << NI) - 1;
        if (rst) begin
            model_reset();
            return;
        end
        edges = 0;
        for (int i = 0; i < NI; i++)
            if (((hist[SS-1] >> i) & 1) == 1 && ((hist[SS] >> i) & 1) == 0) edges |= (1 << i);
        if (model_take()) begin
            id = lowest(m_ip & m_im);
            m_epc = ret_addr; m_exl = 1; m_code = id;
            m_ip &= ~(1 << id);
        end else if (oper == 2'd2) begin
            case (addr_w)
                5'd0: begin
                    m_ie = data_w[0]; m_exl = data_w[1]; m_vec = data_w[2];
                    m_im = (data_w >> 8) & mask;
                end
                5'd1: m_ip &= ~((data_w >> 8) & mask);
                5'd2: m_epc = data_w;
                5'd3: m_ehbr = data_w & 32'hFFFF_FFFC;
                default: ;
            endcase
        end else if (oper == 2'd3) begin
            m_exl = 0;
        end
        m_ip |= edges;
        for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = ir_in;
    endtask

    // One clock: compare DUT against model mid-cycle, then advance the model.
    task automatic cyc();
        logic e_je, e_it;
        logic [31:0] e_ja, e_dr;
        @(negedge clk);
        model_out(e_je, e_ja, e_it, e_dr);
        cap_je = jump_en; cap_ja = jump_addr; cap_it = irq_taken; cap_dr = data_r;
        chk("model jump_en", 32'(cap_je), 32'(e_je));
        chk("model jump_addr", cap_ja, e_ja);
        chk("model irq_taken", 32'(cap_it), 32'(e_it));
        chk("model data_r", cap_dr, e_dr);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        oper = 2'd2; addr_w = a; data_w = d;
        cyc();
        oper = 2'd0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        oper = 2'd1; addr_r = a;
        cyc();
        oper = 2'd0;
        chk(nm, cap_dr, exp);
    endtask

    task automatic eret(input logic [31:0] exp_addr, input string nm);
        oper = 2'd3;
        cyc();
        oper = 2'd0;
        chk({nm, " jump_en"}, 32'(cap_je), 32'd1);
        chk({nm, " jump_addr"}, cap_ja, exp_addr);
    endtask

    task automatic wait_take(input int maxc, input int exp_lat,
                             input logic [31:0] exp_addr, input string nm);
        int n;
        bit got;
        n = 0; got = 0;
        while (n < maxc && !got) begin
            cyc();
            if (cap_je === 1'b1 && cap_it === 1'b1) got = 1;
            else n++;
        end
        chk({nm, " take seen"}, 32'(got), 32'd1);
        if (exp_lat >= 0) chk({nm, " latency"}, 32'(n), 32'(exp_lat));
        chk({nm, " jump_addr"}, cap_ja, exp_addr);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        idle(2);
        chk("reset jump_en", 32'(cap_je), 32'd0);
        rst = 0;
        rd(5'd0, 32'd0, "reset STATUS");
        rd(5'd1, 32'd0, "reset CAUSE");

        // 1: basic take, non-vectored
        ir_en = 1; ret_addr = 32'h40;
        wr(5'd3, 32'h100);
        wr(5'd0, 32'h0301);
        ir_in = 4'b0010;
        wait_take(10, SS + 1, 32'h100, "t1");
        rd(5'd2, 32'h40, "t1 EPC");
        rd(5'd1, 32'h4, "t1 CAUSE");
        rd(5'd0, 32'h303, "t1 STATUS");

        // 2: priority and vectored dispatch
        eret(32'h40, "t2 eret0");
        ir_en = 0; ir_in = 0;
        idle(4);
        wr(5'd3, 32'h200);
        wr(5'd0, 32'h0705);
        ir_in = 4'b0101; ir_en = 1; ret_addr = 32'h80;
        wait_take(10, SS + 1, 32'h200, "t2 line0");
        ret_addr = 32'h90;
        eret(32'h80, "t2 eret");
        wait_take(2, 0, 32'h220, "t2 line2");
        rd(5'd2, 32'h90, "t2 EPC");

        // 3: EXL blocks re-entry
        ir_in = 0; idle(4);
        ir_in = 4'b0001; idle(4);
        rd(5'd1, 32'h108, "t3 CAUSE");
        eret(32'h90, "t3 eret");
        wait_take(1, 0, 32'h200, "t3 take");

        // 4: masked pending, W1C, set beats clear
        wr(5'd0, 32'h0501);
        ir_in = 0; idle(4);
        ir_in = 4'b0010; idle(4);
        rd(5'd1, 32'h200, "t4 masked IP1");
        wr(5'd1, 32'h200);
        rd(5'd1, 32'h0, "t4 W1C");
        ir_in = 0; idle(4);
        ir_in = 4'b0010; idle(4);
        ir_in = 0; idle(4);
        ir_in = 4'b0010; idle(2);
        wr(5'd1, 32'h200);
        rd(5'd1, 32'h200, "t4 set wins");

        // 5: take beats MTC0; ir_en gating
        ir_en = 0;
        wr(5'd0, 32'h0301);
        idle(1);
        chk("t5 blocked", 32'(cap_je), 32'd0);
        ir_en = 1; ret_addr = 32'h1234;
        wr(5'd2, 32'hDEAD);
        chk("t5 take jump_en", 32'(cap_je), 32'd1);
        chk("t5 take irq_taken", 32'(cap_it), 32'd1);
        chk("t5 take addr", cap_ja, 32'h200);
        rd(5'd2, 32'h1234, "t5 EPC");
        rd(5'd0, 32'h303, "t5 STATUS");

        // 6: reset while take pending
        ir_en = 0;
        wr(5'd0, 32'h0301);
        ir_in = 0; idle(4);
        ir_in = 4'b0010; idle(4);
        ir_in = 0; ir_en = 1; rst = 1;
        idle(1);
        chk("t6 rst jump_en", 32'(cap_je), 32'd0);
        chk("t6 rst irq_taken", 32'(cap_it), 32'd0);
        rst = 0; ir_en = 0;
        rd(5'd0, 32'd0, "t6 STATUS");
        rd(5'd1, 32'd0, "t6 CAUSE");
        rd(5'd2, 32'd0, "t6 EPC");
        rd(5'd3, 32'd0, "t6 EHBR");
        wr(5'd3, 32'h303);
        rd(5'd3, 32'h300, "t6 EHBR low bits");
        wr(5'd7, 32'hFFFF);
        rd(5'd7, 32'd0, "t6 unmapped");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
